// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
//   Producer side of the 4-bit ALU Control bus. Decodes ALUOp/funct/opcode
//   from the ID stage into a 4-bit ALU Control code. Registers the result as
//   the ID/EX pipeline register, with valid/stall/flush handling and an
//   illegal-encoding flag.
//
// Optional feature macro: ALU_CTRL_ILLEGAL_CNT_EN
//   When defined, adds the illegal_cnt output. This is a saturating count of
//   the illegal ops loaded into EX. When undefined, the port and its logic
//   are absent.
//
// Parameters
//   CNT_W        width of illegal_cnt (used only with the macro defined)
//   ILLEGAL_CTRL Control value emitted for illegal encodings
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   id_valid     ID holds a valid instruction this cycle
//   id_aluop     00 add, 01 sub, 10 R-type via funct, 11 I-type via opcode
//   id_funct     instr[5:0]
//   id_opcode    instr[31:26]
//   stall        hold EX register contents
//   flush        squash EX register (insert bubble), overrides stall
//   ex_valid     EX register holds a valid op
//   ex_control   Control to the ALU
//   ex_illegal   the op in EX had an illegal encoding
//   illegal_cnt  illegal ops accepted (macro builds only)

module alu_ctrl_stage #(
  parameter int         CNT_W        = 8,
  parameter logic [3:0] ILLEGAL_CTRL = 4'b0010
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_aluop,
  input  logic [5:0]       id_funct,
  input  logic [5:0]       id_opcode,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_control,
  output logic             ex_illegal
`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  ,
  output logic [CNT_W-1:0] illegal_cnt
`endif
);

  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  // Returns {illegal, control}. Only the funct/opcode lookups can be illegal.
  function automatic logic [4:0] decode_ctrl(
    input logic [1:0] aluop,
    input logic [5:0] funct,
    input logic [5:0] opcode
  );
    logic [4:0] res;
    res = {1'b1, ILLEGAL_CTRL};
    case (aluop)
      2'b00: res = {1'b0, CTRL_ADD};
      2'b01: res = {1'b0, CTRL_SUB};
      2'b10: begin
        case (funct)
          6'b100000: res = {1'b0, CTRL_ADD};
          6'b100010: res = {1'b0, CTRL_SUB};
          6'b100100: res = {1'b0, CTRL_AND};
          6'b100101: res = {1'b0, CTRL_OR};
          6'b101010: res = {1'b0, CTRL_SLT};
          default:   res = {1'b1, ILLEGAL_CTRL};
        endcase
      end
      2'b11: begin
        case (opcode)
          6'b001000: res = {1'b0, CTRL_ADD};
          6'b001100: res = {1'b0, CTRL_AND};
          6'b001101: res = {1'b0, CTRL_OR};
          6'b001010: res = {1'b0, CTRL_SLT};
          default:   res = {1'b1, ILLEGAL_CTRL};
        endcase
      end
      default: res = {1'b1, ILLEGAL_CTRL};
    endcase
    return res;
  endfunction

  logic [3:0] decoded_ctrl_s;
  logic       decoded_illegal_s;
  logic       load_s;

  // Combinational decode of the ID inputs and the register load enable.
  always_comb begin
    {decoded_illegal_s, decoded_ctrl_s} = decode_ctrl(id_aluop, id_funct, id_opcode);
    load_s = ~flush & ~stall;
  end

  // ID/EX register: reset, then flush, then stall, then load.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_control <= 4'b0000;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid   <= 1'b0;
      ex_control <= 4'b0000;
      ex_illegal <= 1'b0;
    end else if (stall) begin
      ex_valid   <= ex_valid;
      ex_control <= ex_control;
      ex_illegal <= ex_illegal;
    end else begin
      // Control loads even for bubbles; only valid and illegal are qualified.
      ex_valid   <= id_valid;
      ex_control <= decoded_ctrl_s;
      ex_illegal <= decoded_illegal_s & id_valid;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_CNT_EN
  // Saturating count of illegal ops actually loaded into EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_cnt <= {CNT_W{1'b0}};
    end else if (load_s && id_valid && decoded_illegal_s && !(&illegal_cnt)) begin
      illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      illegal_cnt <= illegal_cnt;
    end
  end
`endif

endmodule
